// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and helpers for the APB master bridge
//
// Contents:
//   state_e : bridge FSM states (IDLE, SETUP, ACCESS, RESP)
//   err_e   : response codes returned on rsp_err
//   sel_w() : number of upper address bits used for slave selection
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK  = 2'd0,
    ERR_SLV = 2'd1,
    ERR_DEC = 2'd2,
    ERR_TMO = 2'd3
  } err_e;

  // A single slave still needs one select bit so the decode slice is never empty.
  function automatic int sel_w(input int nslv);
    return (nslv <= 1) ? 1 : $clog2(nslv);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - combinational slave index decode from upper address bits
//
// Ports:
//   addr       in  ADDR_W  byte address
//   idx        out SEL_W   slave index taken from addr[ADDR_W-1 -: SEL_W]
//   decode_err out 1       index does not map to an existing slave
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NSLV   = 4,
  parameter int SEL_W  = sel_w(NSLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  idx,
  output logic              decode_err
);

  // One extra bit so NSLV itself is representable (e.g. NSLV=16 with SEL_W=4).
  localparam logic [SEL_W:0] NSLV_L = (SEL_W + 1)'(NSLV);

  assign idx        = addr[ADDR_W-1 -: SEL_W];
  assign decode_err = ({1'b0, idx} >= NSLV_L);

endmodule

// File: rtl/apb_bridge_nslv.sv
// rtl/apb_bridge_nslv.sv - APB master bridge from a CPU valid/ready request to NSLV slaves
//
// Ports:
//   pclk, Reset_n                 clock, synchronous active-low reset
//   req_valid/req_ready           CPU request handshake
//   req_write/addr/wdata/strb     CPU request payload (sampled in IDLE only)
//   rsp_valid/rsp_rdata/rsp_err   one-cycle response pulse with data and status
//   err_cnt                       saturating count of non-OK responses
//   psel/penable/pwrite/paddr/pwdata/pstrb   APB master outputs
//   pready/prdata/pslverr         per-slave APB returns
module apb_bridge_nslv
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NSLV        = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   pclk,
  input  logic                   Reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_strb,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [1:0]             rsp_err,
  output logic [7:0]             err_cnt,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  output logic [DATA_W/8-1:0]    pstrb,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pslverr
);

  localparam int SEL_W  = sel_w(NSLV);
  localparam int STRB_W = DATA_W / 8;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

  state_e              state_q, state_d;
  logic [NSLV-1:0]     psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  err_e                rsp_err_q, rsp_err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  logic [SEL_W-1:0]    dec_idx;
  logic                dec_err;
  logic [NSLV-1:0]     sel_onehot;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;

  apb_addr_decode #(
    .ADDR_W (ADDR_W),
    .NSLV   (NSLV),
    .SEL_W  (SEL_W)
  ) u_decode (
    .addr       (req_addr),
    .idx        (dec_idx),
    .decode_err (dec_err)
  );

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (dec_idx == i[SEL_W-1:0]) sel_onehot[i] = 1'b1;
    end
  end

  // The registered psel is the mux select for the slave returns, so
  // non-selected slaves never influence the transfer.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (psel_q[i]) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    tmo_d       = tmo_q;
    err_cnt_d   = err_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = ERR_OK;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_err) begin
            // Unmapped slave: answer straight away, APB pins untouched.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_DEC;
          end else begin
            state_d  = SETUP;
            psel_d   = sel_onehot;
            pwrite_d = req_write;
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
            pstrb_d  = req_write ? req_strb : '0;
            tmo_d    = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err ? ERR_SLV : ERR_OK;
          rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
        end else if (tmo_q == TMO_MAX) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Counted as the error response is issued so err_cnt moves with rsp_valid.
    if (rsp_valid_d && (rsp_err_d != ERR_OK) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      tmo_q       <= '0;
      err_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      tmo_q       <= tmo_d;
      err_cnt_q   <= err_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE) && Reset_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// tb/tb_apb_bridge_nslv.sv - bench for apb_bridge_nslv (NSLV=4 main instance, NSLV=3 decode instance)
module tb_apb_bridge_nslv;

  logic        pclk;
  logic        Reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [7:0]  err_cnt;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [3:0]  pready;
  logic [127:0] prdata;
  logic [3:0]  pslverr;

  logic        req_valid2;
  logic        req_ready2;
  logic        rsp_valid2;
  logic [31:0] rsp_rdata2;
  logic [1:0]  rsp_err2;
  logic [7:0]  err_cnt2;
  logic [2:0]  psel2;
  logic        penable2;
  logic        pwrite2;
  logic [7:0]  paddr2;
  logic [31:0] pwdata2;
  logic [3:0]  pstrb2;
  logic [2:0]  pready2;
  logic [95:0] prdata2;
  logic [2:0]  pslverr2;

  int n_chk;
  int n_err;
  int exp_cnt;

  apb_bridge_nslv #(.ADDR_W(8), .DATA_W(32), .NSLV(4), .TIMEOUT_CYC(16)) dut (
    .pclk(pclk), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  apb_bridge_nslv #(.ADDR_W(8), .DATA_W(32), .NSLV(3), .TIMEOUT_CYC(16)) dut3 (
    .pclk(pclk), .Reset_n(Reset_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .err_cnt(err_cnt2),
    .psel(psel2), .penable(penable2), .pwrite(pwrite2), .paddr(paddr2),
    .pwdata(pwdata2), .pstrb(pstrb2),
    .pready(pready2), .prdata(prdata2), .pslverr(pslverr2)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic [31:0] sdata;
    logic [3:0]  exp_psel;
    logic [3:0]  exp_pstrb;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string nm);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge pclk);
    @(negedge pclk);
  endtask

  // Called at a negedge with the bridge idle; request accepted at the next edge (edge 0).
  task automatic run_vec(input vec_t v, input int id);
    bit seen;
    int lat;
    string t;
    t = $sformatf("v%0d", id);
    chk(req_ready, 1'b1, {t, "_ready_idle"});
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    // Non-selected slaves look ready/erroring with junk data; the bridge must ignore them.
    pready  = ~v.exp_psel;
    pslverr = ~v.exp_psel | (v.slverr ? v.exp_psel : 4'b0000);
    for (int i = 0; i < 4; i++)
      prdata[i*32 +: 32] = v.exp_psel[i] ? v.sdata : (32'hBAD0_0000 | i);
    step();
    req_valid = 1'b0;
    req_addr  = 8'h3F;
    req_wdata = 32'h0;
    req_strb  = 4'h0;
    req_write = ~v.write;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (c == 1) begin
        chk(psel, v.exp_psel, {t, "_setup_psel"});
        chk(penable, 1'b0, {t, "_setup_penable"});
        chk(paddr, v.addr, {t, "_setup_paddr"});
        chk(pwrite, v.write, {t, "_setup_pwrite"});
        chk(pstrb, v.exp_pstrb, {t, "_setup_pstrb"});
        if (v.write) chk(pwdata, v.wdata, {t, "_setup_pwdata"});
      end
      if (c == 2) begin
        chk(psel, v.exp_psel, {t, "_access_psel"});
        chk(penable, 1'b1, {t, "_access_penable"});
        chk(paddr, v.addr, {t, "_access_paddr"});
      end
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = c;
        chk(rsp_err, v.exp_err, {t, "_rsp_err"});
        chk(rsp_rdata, v.exp_rdata, {t, "_rsp_rdata"});
        chk(psel, 4'b0000, {t, "_resp_psel"});
        chk(penable, 1'b0, {t, "_resp_penable"});
      end else begin
        pready = ~v.exp_psel | ((c >= 2 + v.waits) ? v.exp_psel : 4'b0000);
        step();
      end
    end
    chk(seen, 1'b1, {t, "_rsp_seen"});
    chk(lat, v.exp_lat, {t, "_latency"});
    if (v.exp_err != 2'd0 && exp_cnt < 255) exp_cnt++;
    step();
    chk(rsp_valid, 1'b0, {t, "_rsp_pulse_len"});
    chk(rsp_err, 2'd0, {t, "_rsp_err_clr"});
    chk(rsp_rdata, 32'h0, {t, "_rsp_rdata_clr"});
    chk(req_ready, 1'b1, {t, "_ready_back"});
    chk(err_cnt, exp_cnt, {t, "_err_cnt"});
  endtask

  // Decode-error request on the NSLV=3 instance (address 0xC0 -> index 3).
  task automatic dec_once(input bit do_chk);
    req_valid2 = 1'b1;
    req_write  = 1'b0;
    req_addr   = 8'hC0;
    step();
    req_valid2 = 1'b0;
    if (do_chk) begin
      chk(rsp_valid2, 1'b1, "dec_rsp_valid");
      chk(rsp_err2, 2'd2, "dec_rsp_err");
      chk(rsp_rdata2, 32'h0, "dec_rsp_rdata");
      chk(psel2, 3'b000, "dec_psel");
      chk(penable2, 1'b0, "dec_penable");
    end
    step();
    if (do_chk) begin
      chk(rsp_valid2, 1'b0, "dec_rsp_clr");
      chk(req_ready2, 1'b1, "dec_ready_back");
      chk(psel2, 3'b000, "dec_psel_after");
    end
  endtask

  initial begin
    bit spurious;
    n_chk = 0;
    n_err = 0;
    exp_cnt = 0;

    //            wr    addr   wdata         strb  wt  se    sdata         psel     pstrb    err   rdata         lat
    vecs[0] = '{1'b1, 8'h45, 32'hDEADBEEF, 4'hF, 0,  1'b0, 32'h0,        4'b0010, 4'hF, 2'd0, 32'h0,        3};
    vecs[1] = '{1'b0, 8'hC0, 32'h0,        4'hF, 2,  1'b0, 32'h12345678, 4'b1000, 4'h0, 2'd0, 32'h12345678, 5};
    vecs[2] = '{1'b0, 8'h10, 32'h0,        4'h0, 0,  1'b0, 32'hA5A50001, 4'b0001, 4'h0, 2'd0, 32'hA5A50001, 3};
    vecs[3] = '{1'b1, 8'h80, 32'hCAFEF00D, 4'h5, 1,  1'b0, 32'h0,        4'b0100, 4'h5, 2'd0, 32'h0,        4};
    vecs[4] = '{1'b0, 8'h81, 32'h0,        4'h0, 0,  1'b1, 32'hFFFFFFFF, 4'b0100, 4'h0, 2'd1, 32'h0,        3};
    vecs[5] = '{1'b0, 8'h04, 32'h0,        4'h0, 99, 1'b0, 32'h11111111, 4'b0001, 4'h0, 2'd3, 32'h0,        19};
    vecs[6] = '{1'b1, 8'hFF, 32'h01020304, 4'h3, 0,  1'b1, 32'h0,        4'b1000, 4'h3, 2'd1, 32'h0,        3};

    Reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_valid2 = 1'b0;
    req_write  = 1'b0;
    req_addr   = 8'h0;
    req_wdata  = 32'h0;
    req_strb   = 4'h0;
    pready     = 4'h0;
    pslverr    = 4'h0;
    prdata     = '0;
    pready2    = 3'b111;
    pslverr2   = 3'b000;
    prdata2    = '0;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk(req_ready, 1'b0, "rst_req_ready");
    chk(psel, 4'h0, "rst_psel");
    chk(penable, 1'b0, "rst_penable");
    chk(rsp_valid, 1'b0, "rst_rsp_valid");
    chk(err_cnt, 8'h0, "rst_err_cnt");
    chk({pwrite, paddr, pwdata, pstrb}, 45'h0, "rst_apb_data");
    Reset_n = 1'b1;
    step();
    chk(req_ready, 1'b1, "rst_release_ready");

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    dec_once(1'b1);
    chk(err_cnt2, 8'd1, "dec_err_cnt");
    for (int k = 0; k < 300; k++) dec_once(1'b0);
    chk(err_cnt2, 8'd255, "err_cnt_saturate");

    // Reset while the transfer sits in ACCESS with pready held low.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h45;
    req_wdata = 32'h55AA55AA;
    req_strb  = 4'hF;
    pready    = 4'b1101;
    pslverr   = 4'b0000;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk(penable, 1'b1, "midrst_in_access");
    Reset_n = 1'b0;
    step();
    chk(psel, 4'h0, "midrst_psel");
    chk(penable, 1'b0, "midrst_penable");
    chk(rsp_valid, 1'b0, "midrst_rsp_valid");
    chk(req_ready, 1'b0, "midrst_req_ready");
    chk(err_cnt, 8'h0, "midrst_err_cnt");
    chk({pwrite, paddr, pwdata, pstrb, rsp_err, rsp_rdata}, 79'h0, "midrst_outputs");
    chk(err_cnt2, 8'h0, "midrst_err_cnt2");
    Reset_n = 1'b1;
    step();
    chk(req_ready, 1'b1, "midrst_release_ready");
    spurious = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid) spurious = 1'b1;
      step();
    end
    chk(spurious, 1'b0, "midrst_no_rsp");
    exp_cnt = 0;
    run_vec(vecs[0], 10);
    run_vec(vecs[1], 11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_bridge_nslv.md
# apb_bridge_nslv

Parametrised APB master bridge: accepts single read/write requests from the CPU side over a valid/ready handshake and runs APB3/APB4 SETUP/ACCESS transfers to one of NSLV slaves. Slave selection comes from upper address bits. Replaces the fixed two-slave, 5-bit-address bridge. Adds byte strobes, slave-error pass-through, decode-error and timeout detection, and a saturating error counter. Sits between the CPU model and the UART/GPIO slave blocks.

## Interface
- ADDR_W, 8, address width; upper SEL_W bits select slave, SEL_W = max(1, $clog2(NSLV))
- DATA_W, 32, data width; multiple of 8
- NSLV, 4, number of slaves, 1..16
- TIMEOUT_CYC, 16, max ACCESS cycles with pready low before abort, >= 1
- pclk  in  1  bus clock, all logic rising-edge
- Reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  CPU request valid
- req_ready  out  1  bridge can accept; = (state==IDLE) & Reset_n
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and all errors
- rsp_err  out  2  0 OK, 1 SLVERR, 2 DECODE, 3 TIMEOUT
- err_cnt  out  8  saturating count of non-OK responses
- psel  out  NSLV  one-hot slave select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pstrb  out  DATA_W/8  APB strobes; 0 on reads
- pready  in  NSLV  per-slave ready
- prdata  in  NSLV*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
- pslverr  in  NSLV  per-slave error

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_valid & req_ready latches write/addr/wdata/strb.
  - Decoded index idx = req_addr[ADDR_W-1 -: SEL_W].
  - idx < NSLV -> SETUP. idx >= NSLV -> RESP with err 2; no APB activity.
- SETUP: psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb driven from latched request. Unconditionally -> ACCESS.
- ACCESS:
  - psel[idx]=1, penable=1, all APB outputs held stable.
  - pready[idx]=1 -> capture prdata slice idx (reads only) and pslverr[idx] -> RESP with err 1 or 0.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYC -> RESP with err 3; psel and penable drop in that same RESP cycle.
- RESP:
  - rsp_valid=1 for exactly one cycle; psel=0, penable=0.
  - If rsp_err != 0, err_cnt increments, saturating at 255.
  - -> IDLE.
- pready, prdata and pslverr of non-selected slaves are ignored.
- Reads with pslverr: rsp_rdata = 0.

## Timing
- Reset (Reset_n low at posedge): state IDLE.
  - All outputs 0: psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, err_cnt, timeout counter.
  - req_ready = 0 while Reset_n low; req_ready = 1 on the first cycle after release.
- Reset mid-transfer aborts at that edge: psel and penable are 0 next cycle, and no rsp_valid is issued for the aborted request.
- Zero-wait transfer, request accepted at edge 0:
  - SETUP visible cycle 1, ACCESS cycle 2.
  - With pready in cycle 2: rsp_valid in cycle 3; req_ready back high in cycle 4.
  - Throughput is one transfer per 4 cycles.
- Each pready-low cycle in ACCESS adds one cycle of latency.
- Decode error: rsp_valid one cycle after acceptance.
- Timeout: rsp_valid exactly TIMEOUT_CYC+1 cycles after ACCESS entry.
- APB outputs change only on SETUP entry and are held through ACCESS. paddr/pwdata/pstrb/pwrite keep their last values in IDLE/RESP; only psel and penable return to 0.
- rsp_rdata and rsp_err are valid only while rsp_valid is high; both are cleared to 0 the cycle after.
- req_* inputs are ignored outside IDLE.

## Structure
- Shared package apb_pkg:
  - state enum (IDLE/SETUP/ACCESS/RESP);
  - error codes ERR_OK, ERR_SLV, ERR_DEC, ERR_TMO;
  - helper function for SEL_W.
- One sub-module, apb_addr_decode (combinational): ADDR_W/NSLV in, idx and decode_err out. Reusable by slave-side muxes.
- FSM, request latch, timeout counter and err_cnt stay in apb_bridge_nslv.

## Test plan
- Write addr 0x45, wdata 0xDEADBEEF, strb 0xF, slave 1 zero-wait -> psel=4'b0010 with penable=0 at cycle 1, penable=1 at cycle 2; rsp_valid at cycle 3 with err 0; pstrb=0xF.
- Read addr 0xC0 from slave 3 with 2 wait states, prdata=0x12345678 -> rsp_rdata=0x12345678, err 0, rsp_valid at cycle 5, pstrb=0.
- NSLV=3, read addr 0xC0 -> rsp err 2 at cycle 1, psel stays 0, err_cnt=1.
- Slave 0 holds pready low, TIMEOUT_CYC=16 -> rsp err 3 exactly 17 cycles after ACCESS entry, psel=0 in the RESP cycle, err_cnt increments.
- Read with pready=1, pslverr=1 -> rsp err 1, rsp_rdata=0; 300 error responses -> err_cnt saturates at 255.
- Reset_n low during ACCESS -> next cycle all outputs 0 and no rsp_valid; a new request after release completes normally.
